// File: rtl/player_motion_ctrl.sv
// Player box X-position controller: synchronises left/right buttons and moves the box once per frame on blanking line TICK_Y.
// Build option: define PLAYER_WRAP_EN to wrap at the screen edges instead of clamping.
module player_motion_ctrl #(
  parameter logic [9:0] SCREEN_WIDTH = 10'd640,
  parameter logic [9:0] BOX_WIDTH    = 10'd30,
  parameter logic [9:0] START_X      = 10'd305,
  parameter logic [9:0] TICK_Y       = 10'd480,
  parameter logic [3:0] MIN_STEP     = 4'd1,
  parameter logic [3:0] MAX_STEP     = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [9:0] player_x,
  output logic       frame_tick,
  output logic [1:0] dir
);

  localparam logic [1:0]  IDLE  = 2'b00;
  localparam logic [1:0]  LEFT  = 2'b01;
  localparam logic [1:0]  RIGHT = 2'b10;
  localparam logic [10:0] MAX_X = {1'b0, SCREEN_WIDTH} - {1'b0, BOX_WIDTH};

  logic       bl_meta_q, bl_q, br_meta_q, br_q;
  logic       tick_s;
  logic [1:0] state_q, state_d;
  logic [3:0] speed_q, speed_d;
  logic [9:0] pos_q, pos_d;
  logic       frame_tick_q;
  logic [10:0] pos_ext_s, speed_ext_s, sum_s, diff_s, left_wrap_s, right_wrap_s;

  // Two-flop synchronisers for the raw buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bl_meta_q <= 1'b0;
      bl_q      <= 1'b0;
      br_meta_q <= 1'b0;
      br_q      <= 1'b0;
    end else begin
      bl_meta_q <= btn_left;
      bl_q      <= bl_meta_q;
      br_meta_q <= btn_right;
      br_q      <= br_meta_q;
    end
  end

  assign tick_s = (x == 10'd0) && (y == TICK_Y);

  // State register: direction, speed and position only advance on the frame tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      speed_q      <= MIN_STEP;
      pos_q        <= START_X;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= tick_s;
      if (tick_s) begin
        state_q <= state_d;
        speed_q <= speed_d;
        pos_q   <= pos_d;
      end
    end
  end

  // Next-state logic: both or neither button pressed means IDLE
  always_comb begin
    state_d = state_q;
    if (tick_s) begin
      case ({bl_q, br_q})
        2'b10:   state_d = LEFT;
        2'b01:   state_d = RIGHT;
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Speed ramp restarts on any direction change, including a direct reversal
  always_comb begin
    speed_d = speed_q;
    if (tick_s) begin
      if ((state_d != state_q) || (state_d == IDLE)) begin
        speed_d = MIN_STEP;
      end else if (speed_q >= MAX_STEP) begin
        speed_d = MAX_STEP;
      end else begin
        speed_d = speed_q + 4'd1;
      end
    end else begin
      speed_d = speed_q;
    end
  end

  assign pos_ext_s    = {1'b0, pos_q};
  assign speed_ext_s  = {7'd0, speed_d};
  assign sum_s        = pos_ext_s + speed_ext_s;
  assign diff_s       = pos_ext_s - speed_ext_s;
  assign left_wrap_s  = pos_ext_s + MAX_X + 11'd1 - speed_ext_s;
  assign right_wrap_s = sum_s - (MAX_X + 11'd1);

  // Position update uses the speed chosen on this same tick
  always_comb begin
    pos_d = pos_q;
    if (tick_s) begin
      case (state_d)
        LEFT: begin
          if (pos_ext_s < speed_ext_s) begin
`ifdef PLAYER_WRAP_EN
            pos_d = left_wrap_s[9:0];
`else
            pos_d = 10'd0;
`endif
          end else begin
            pos_d = diff_s[9:0];
          end
        end
        RIGHT: begin
          if (sum_s > MAX_X) begin
`ifdef PLAYER_WRAP_EN
            pos_d = right_wrap_s[9:0];
`else
            pos_d = MAX_X[9:0];
`endif
          end else begin
            pos_d = sum_s[9:0];
          end
        end
        default: pos_d = pos_q;
      endcase
    end else begin
      pos_d = pos_q;
    end
  end

  assign player_x   = pos_q;
  assign frame_tick = frame_tick_q;
  assign dir        = state_q;

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
Upstream producer of player_x for the VGA renderer stage. Samples raw left/right buttons, picks a direction with a small FSM, and updates the box X position once per frame during vertical blanking, so the renderer never sees a mid-frame change. Speed ramps from MIN_STEP up to MAX_STEP while a direction is held. Position is clamped to the visible screen.

Parameters:
SCREEN_WIDTH, 10'd640, visible pixels per line.
BOX_WIDTH, 10'd30, player box width; must match the renderer's BOX_WIDTH.
START_X, 10'd305, reset position, centred: (640-30)/2.
TICK_Y, 10'd480, line on which the per-frame update occurs; first non-active line.
MIN_STEP, 4'd1, pixels moved on the first update frame of a press.
MAX_STEP, 4'd8, speed ceiling in pixels per frame.

Ports:
clk  input  1  pixel clock, the same clock that drives the timing generator's x/y.
rst  input  1  asynchronous, active-high reset.
btn_left  input  1  raw button, active-high, asynchronous to clk.
btn_right  input  1  raw button, active-high, asynchronous to clk.
x  input  10  current pixel X from the timing generator.
y  input  10  current pixel Y from the timing generator.
player_x  output  10  registered box left edge, fed to the renderer.
frame_tick  output  1  registered one-cycle pulse, coincident with each player_x update opportunity.
dir  output  2  registered FSM state: 00 IDLE, 01 LEFT, 10 RIGHT.

Behaviour:
- Design uses one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - player_x = START_X.
  - frame_tick = 0.
  - dir = IDLE.
  - Internal speed = MIN_STEP.
  - Both 2-flop button synchronisers = 0.
- Synchronisation: each button passes through 2 flops. Only the synchronised values (bl, br) are used, giving 2 cycles of input latency.
- Tick detect: tick = (x == 0) && (y == TICK_Y), combinational.
  - All state, speed and position updates happen only on the clk edge where tick = 1.
  - frame_tick goes high on that same edge for exactly 1 cycle.
  - player_x and frame_tick both change on that edge, so the new position is valid in the same cycle frame_tick is high.
- FSM next state, evaluated only on tick:
  - bl & ~br → LEFT.
  - br & ~bl → RIGHT.
  - Both pressed or neither pressed → IDLE.
- Speed, evaluated only on tick:
  - When the next state differs from the current state (including a direct LEFT↔RIGHT reversal), speed = MIN_STEP for this move.
  - When the next state equals the current state and is not IDLE, speed = min(speed + 1, MAX_STEP).
  - In IDLE, speed = MIN_STEP and player_x holds.
- Move rule: the move on a tick uses the speed value selected on that same tick.
- Arithmetic: compute in 11 bits to avoid wrap. MAX_X = SCREEN_WIDTH - BOX_WIDTH (610 with defaults).
  - LEFT: if player_x < speed then player_x = 0, else player_x = player_x - speed.
  - RIGHT: if player_x + speed > MAX_X then player_x = MAX_X, else player_x = player_x + speed.
- Boundaries:
  - At 0 with LEFT held, or at MAX_X with RIGHT held: player_x holds, and the speed ramp continues.
  - A button change between ticks has no effect until the next tick.
  - A press shorter than one frame, if it misses the tick, is ignored.
- Reset mid-frame: all outputs return to reset values immediately. The next movement occurs on the first tick after rst deasserts.

Optional Feature:
PLAYER_WRAP_EN.
- Defined: the edges wrap modulo MAX_X + 1 instead of clamping.
  - LEFT with player_x < speed: player_x = player_x + MAX_X + 1 - speed.
  - RIGHT with player_x + speed > MAX_X: player_x = player_x + speed - (MAX_X + 1).
- Undefined: clamp behaviour exactly as specified in Behaviour.

Test Plan:
- Reset: assert rst mid-frame → player_x = 305, dir = 00, frame_tick = 0, all asynchronously. After release, no change until x = 0, y = 480.
- Hold btn_right over 10 ticks from 305 → successive player_x = 306, 308, 311, 315, 320, 326, 333, 341, 349, 357 (step saturates at 8). frame_tick pulses once per frame.
- Right clamp: start near the edge (run right until clamped) → player_x stops at 610 and never exceeds it. Release → dir = 00 on the next tick and player_x holds at 610.
- Both buttons held → dir = 00 and player_x unchanged across 3 ticks. Reversal LEFT→RIGHT at speed 8 → first RIGHT move is +1.
- Button pulse lasting 100 cycles entirely between ticks → no movement. Button held only across one tick → exactly one move of MIN_STEP.
- With PLAYER_WRAP_EN, from player_x = 1 and LEFT at speed 1, then 2 → player_x = 0, then 609. Without the macro, the same sequence → 0, then 0.
